// File: rtl/fetch_mem_arbiter.sv
// fetch_mem_arbiter
//   Shares the single instruction memory/TLB read port between the fetch
//   frontend, the page-table walker and the debug/loader port. Grants are
//   combinational; each issued read pushes a tag into a LAT-deep pipeline
//   whose tail steers the returning data to its owner. Frontend flushes
//   mark in-flight fetch tags as killed so their data is never delivered.
//
// Ports
//   clk, rst_n, clk_en         clock, async active-low reset, global enable
//   fetch_req/addr/flush       fetch request, address, redirect kill
//   fetch_gnt/stall/rvalid     fetch grant, hold, response valid
//   walk_req/lock/addr         walker request, multi-beat lock, address
//   walk_gnt/rvalid            walker grant, response valid
//   dbg_req/we/addr/wdata      debug request (read or write)
//   dbg_gnt/rvalid             debug grant (write ack), read response valid
//   mem_re/we/addr/wdata       memory macro command
//   mem_rdata -> rdata         read data, qualified by the *_rvalid outputs
module fetch_mem_arbiter #(
    parameter int LAT      = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    input  logic        fetch_flush,
    output logic        fetch_gnt,
    output logic        fetch_stall,
    output logic        fetch_rvalid,
    input  logic        walk_req,
    input  logic        walk_lock,
    input  logic [31:0] walk_addr,
    output logic        walk_gnt,
    output logic        walk_rvalid,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] rdata
);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;
    localparam logic [1:0] SRC_F    = 2'd0;
    localparam logic [1:0] SRC_W    = 2'd1;
    localparam logic [1:0] SRC_D    = 2'd2;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [3:0]           r_dbg_wait;
    logic [LAT-1:0]       r_pv;
    logic [LAT-1:0]       r_pkill;
    logic [LAT-1:0][1:0]  r_psrc;
    logic                 w_en, w_promote, w_fgnt, w_wgnt, w_dgnt, w_rd, w_live;
    logic [1:0]           w_src;

    // Reset also blocks grants so nothing issues while rst_n is low.
    assign w_en      = clk_en & rst_n;
    assign w_promote = (r_dbg_wait == 4'(MAX_WAIT));

    always_comb begin
        w_fgnt = 1'b0;
        w_wgnt = 1'b0;
        w_dgnt = 1'b0;
        if (w_en) begin
            if (r_state == S_LOCKED)                w_wgnt = walk_req;
            else if (walk_req)                      w_wgnt = 1'b1;
            else if (dbg_req && w_promote)          w_dgnt = 1'b1;
            else if (fetch_req && !fetch_flush)     w_fgnt = 1'b1;
            else if (dbg_req)                       w_dgnt = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_IDLE) begin
            if (w_wgnt && walk_lock) w_state_nxt = S_LOCKED;
        end else begin
            // Stay only while the walker keeps a locked beat going.
            if (!(walk_req && walk_lock)) w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_state <= S_IDLE;
        else if (clk_en) r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dbg_wait <= 4'd0;
        end else if (clk_en) begin
            if (!dbg_req || w_dgnt)             r_dbg_wait <= 4'd0;
            else if (r_dbg_wait < 4'(MAX_WAIT)) r_dbg_wait <= r_dbg_wait + 4'd1;
        end
    end

    assign w_rd  = w_fgnt | w_wgnt | (w_dgnt & ~dbg_we);
    assign w_src = w_wgnt ? SRC_W : (w_dgnt ? SRC_D : SRC_F);

    // Tag pipeline: a flush marks every fetch tag as it shifts; the tail
    // itself is suppressed combinationally below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv    <= '0;
            r_pkill <= '0;
            r_psrc  <= '0;
        end else if (clk_en) begin
            for (int i = LAT - 1; i > 0; i--) begin
                r_pv[i]    <= r_pv[i-1];
                r_psrc[i]  <= r_psrc[i-1];
                r_pkill[i] <= r_pkill[i-1] | (fetch_flush && (r_psrc[i-1] == SRC_F));
            end
            r_pv[0]    <= w_rd;
            r_psrc[0]  <= w_src;
            r_pkill[0] <= 1'b0;
        end
    end

    // Responses are handed over only on enabled cycles so a held tail is
    // not delivered twice.
    assign w_live       = r_pv[LAT-1] & ~r_pkill[LAT-1] & clk_en;
    assign fetch_rvalid = w_live & (r_psrc[LAT-1] == SRC_F) & ~fetch_flush;
    assign walk_rvalid  = w_live & (r_psrc[LAT-1] == SRC_W);
    assign dbg_rvalid   = w_live & (r_psrc[LAT-1] == SRC_D);

    assign fetch_gnt   = w_fgnt;
    assign walk_gnt    = w_wgnt;
    assign dbg_gnt     = w_dgnt;
    assign fetch_stall = fetch_req & ~w_fgnt & ~fetch_flush;

    assign mem_re    = w_rd;
    assign mem_we    = w_dgnt & dbg_we;
    assign mem_wdata = dbg_wdata;
    assign mem_addr  = w_wgnt ? walk_addr :
                       w_dgnt ? dbg_addr  :
                       w_fgnt ? fetch_addr : 32'd0;
    assign rdata     = mem_rdata;
endmodule

// File: tb/tb_fetch_mem_arbiter.sv
module tb_fetch_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n, clk_en;
    logic        fetch_req, fetch_flush, walk_req, walk_lock, dbg_req, dbg_we;
    logic [31:0] fetch_addr, walk_addr, dbg_addr, dbg_wdata;
    logic        fetch_gnt, fetch_stall, fetch_rvalid, walk_gnt, walk_rvalid;
    logic        dbg_gnt, dbg_rvalid, mem_re, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, rdata;

    int n_vec = 0;
    int n_err = 0;

    fetch_mem_arbiter #(.LAT(2), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
        .fetch_gnt(fetch_gnt), .fetch_stall(fetch_stall), .fetch_rvalid(fetch_rvalid),
        .walk_req(walk_req), .walk_lock(walk_lock), .walk_addr(walk_addr),
        .walk_gnt(walk_gnt), .walk_rvalid(walk_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .rdata(rdata)
    );

    always #5 clk = ~clk;

    // Memory macro: word at address a holds 0xC0DE0000|a unless written;
    // read data appears two enabled cycles after mem_re.
    logic        wr_v;
    logic [31:0] wr_a, wr_d, s0, s1;
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (wr_v && wr_a == a) ? wr_d : (32'hC0DE_0000 | a);
    endfunction
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0 <= 32'd0;
            s1 <= 32'd0;
        end else if (clk_en) begin
            s0 <= mem_re ? mem_word(mem_addr) : 32'd0;
            s1 <= s0;
        end
    end
    always @(posedge clk) begin
        if (rst_n && clk_en && mem_we) begin
            wr_v <= 1'b1;
            wr_a <= mem_addr;
            wr_d <= mem_wdata;
        end
    end
    initial wr_v = 1'b0;
    assign mem_rdata = s1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_req = 0; fetch_flush = 0; walk_req = 0; walk_lock = 0;
        dbg_req = 0; dbg_we = 0;
    endtask

    initial begin
        rst_n = 0; clk_en = 1;
        idle_inputs();
        fetch_addr = 0; walk_addr = 0; dbg_addr = 0; dbg_wdata = 0;
        @(negedge clk);
        chk("rst_fetch_rvalid", {31'd0, fetch_rvalid}, 32'd0);
        chk("rst_walk_rvalid",  {31'd0, walk_rvalid},  32'd0);
        chk("rst_dbg_rvalid",   {31'd0, dbg_rvalid},   32'd0);
        chk("rst_mem_re",       {31'd0, mem_re},       32'd0);
        chk("rst_mem_addr",     mem_addr,              32'd0);
        nxt(); rst_n = 1;

        // Back-to-back fetches.
        nxt(); fetch_req = 1; fetch_addr = 32'h400;
        @(negedge clk);
        chk("f1_gnt",   {31'd0, fetch_gnt},   32'd1);
        chk("f1_stall", {31'd0, fetch_stall}, 32'd0);
        chk("f1_addr",  mem_addr,             32'h400);
        chk("f1_re",    {31'd0, mem_re},      32'd1);
        nxt(); fetch_addr = 32'h404;
        @(negedge clk);
        chk("f2_gnt",    {31'd0, fetch_gnt},    32'd1);
        chk("f2_rvalid", {31'd0, fetch_rvalid}, 32'd0);
        nxt(); fetch_addr = 32'h408;
        @(negedge clk);
        chk("f3_gnt",    {31'd0, fetch_gnt},    32'd1);
        chk("f3_stall",  {31'd0, fetch_stall},  32'd0);
        chk("f3_rvalid", {31'd0, fetch_rvalid}, 32'd1);
        chk("f3_rdata",  rdata,                 32'hC0DE_0400);
        nxt(); fetch_req = 0;
        @(negedge clk);
        chk("f4_rvalid", {31'd0, fetch_rvalid}, 32'd1);
        chk("f4_rdata",  rdata,                 32'hC0DE_0404);
        nxt();
        @(negedge clk);
        chk("f5_rvalid", {31'd0, fetch_rvalid}, 32'd1);
        chk("f5_rdata",  rdata,                 32'hC0DE_0408);
        nxt();
        @(negedge clk);
        chk("f6_rvalid", {31'd0, fetch_rvalid}, 32'd0);

        // Locked walker burst against a waiting fetch.
        nxt(); fetch_req = 1; fetch_addr = 32'h500;
        walk_req = 1; walk_lock = 1; walk_addr = 32'h2000;
        @(negedge clk);
        chk("w1_gnt",   {31'd0, walk_gnt},    32'd1);
        chk("w1_stall", {31'd0, fetch_stall}, 32'd1);
        chk("w1_addr",  mem_addr,             32'h2000);
        nxt(); walk_addr = 32'h2004;
        @(negedge clk);
        chk("w2_gnt",   {31'd0, walk_gnt},    32'd1);
        chk("w2_stall", {31'd0, fetch_stall}, 32'd1);
        nxt(); walk_addr = 32'h2008;
        @(negedge clk);
        chk("w3_gnt",    {31'd0, walk_gnt},    32'd1);
        chk("w3_stall",  {31'd0, fetch_stall}, 32'd1);
        chk("w3_rvalid", {31'd0, walk_rvalid}, 32'd1);
        chk("w3_rdata",  rdata,                32'hC0DE_2000);
        nxt(); walk_addr = 32'h200C; walk_lock = 0;
        @(negedge clk);
        chk("w4_gnt",   {31'd0, walk_gnt},    32'd1);
        chk("w4_stall", {31'd0, fetch_stall}, 32'd1);
        nxt(); walk_req = 0;
        @(negedge clk);
        chk("w5_fgnt",  {31'd0, fetch_gnt},   32'd1);
        chk("w5_stall", {31'd0, fetch_stall}, 32'd0);
        nxt(); fetch_req = 0;
        nxt(); nxt(); nxt();

        // Debug read starved by fetch until promoted.
        nxt(); fetch_req = 1; fetch_addr = 32'h600;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h300;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("d_wait_fgnt", {31'd0, fetch_gnt}, 32'd1);
            chk("d_wait_dgnt", {31'd0, dbg_gnt},   32'd0);
            nxt();
        end
        @(negedge clk);
        chk("d5_dgnt",  {31'd0, dbg_gnt},     32'd1);
        chk("d5_fgnt",  {31'd0, fetch_gnt},   32'd0);
        chk("d5_stall", {31'd0, fetch_stall}, 32'd1);
        chk("d5_addr",  mem_addr,             32'h300);
        nxt(); dbg_req = 0;
        @(negedge clk);
        chk("d6_rvalid", {31'd0, dbg_rvalid}, 32'd0);
        nxt();
        @(negedge clk);
        chk("d7_rvalid",  {31'd0, dbg_rvalid},   32'd1);
        chk("d7_frvalid", {31'd0, fetch_rvalid}, 32'd0);
        chk("d7_rdata",   rdata,                 32'hC0DE_0300);
        nxt(); fetch_req = 0;
        nxt(); nxt(); nxt();

        // Flush kills two in-flight fetches.
        nxt(); fetch_req = 1; fetch_addr = 32'h400;
        nxt(); fetch_addr = 32'h404;
        nxt(); fetch_addr = 32'h999; fetch_flush = 1;
        @(negedge clk);
        chk("fl_gnt",    {31'd0, fetch_gnt},    32'd0);
        chk("fl_stall",  {31'd0, fetch_stall},  32'd0);
        chk("fl_re",     {31'd0, mem_re},       32'd0);
        chk("fl_rvalid", {31'd0, fetch_rvalid}, 32'd0);
        nxt(); fetch_flush = 0; fetch_addr = 32'h800;
        @(negedge clk);
        chk("fl1_gnt",    {31'd0, fetch_gnt},    32'd1);
        chk("fl1_rvalid", {31'd0, fetch_rvalid}, 32'd0);
        nxt(); fetch_req = 0;
        @(negedge clk);
        chk("fl2_rvalid", {31'd0, fetch_rvalid}, 32'd0);
        nxt();
        @(negedge clk);
        chk("fl3_rvalid", {31'd0, fetch_rvalid}, 32'd1);
        chk("fl3_rdata",  rdata,                 32'hC0DE_0800);

        // Flush + fetch + dbg together: dbg is granted.
        nxt(); fetch_req = 1; fetch_flush = 1; dbg_req = 1; dbg_we = 0; dbg_addr = 32'h100;
        @(negedge clk);
        chk("fd_dgnt", {31'd0, dbg_gnt},   32'd1);
        chk("fd_fgnt", {31'd0, fetch_gnt}, 32'd0);
        nxt(); idle_inputs();
        nxt();
        @(negedge clk);
        chk("fd_rvalid", {31'd0, dbg_rvalid}, 32'd1);
        chk("fd_rdata",  rdata,               32'hC0DE_0100);

        // Clock enable low blocks everything.
        nxt(); clk_en = 0; fetch_req = 1; fetch_addr = 32'h700;
        @(negedge clk);
        chk("ce_gnt", {31'd0, fetch_gnt}, 32'd0);
        chk("ce_re",  {31'd0, mem_re},    32'd0);
        nxt(); clk_en = 1; fetch_req = 0;
        nxt(); nxt();

        // Debug write then read-back.
        nxt(); dbg_req = 1; dbg_we = 1; dbg_addr = 32'h1000; dbg_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("wr_dgnt",  {31'd0, dbg_gnt}, 32'd1);
        chk("wr_we",    {31'd0, mem_we},  32'd1);
        chk("wr_re",    {31'd0, mem_re},  32'd0);
        chk("wr_wdata", mem_wdata,        32'hDEAD_BEEF);
        nxt(); idle_inputs();
        @(negedge clk);
        chk("wr1_rvalid", {31'd0, dbg_rvalid}, 32'd0);
        nxt();
        @(negedge clk);
        chk("wr2_rvalid", {31'd0, dbg_rvalid}, 32'd0);
        nxt(); dbg_req = 1; dbg_we = 0; dbg_addr = 32'h1000;
        @(negedge clk);
        chk("rb_dgnt", {31'd0, dbg_gnt}, 32'd1);
        nxt(); idle_inputs();
        nxt();
        @(negedge clk);
        chk("rb_rvalid", {31'd0, dbg_rvalid}, 32'd1);
        chk("rb_rdata",  rdata,               32'hDEAD_BEEF);

        // Reset mid-LOCKED with walker reads in flight.
        nxt(); walk_req = 1; walk_lock = 1; walk_addr = 32'h3000;
        nxt(); walk_addr = 32'h3004;
        nxt(); rst_n = 0;
        #1;
        chk("rl_wgnt",   {31'd0, walk_gnt},    32'd0);
        chk("rl_re",     {31'd0, mem_re},      32'd0);
        chk("rl_rvalid", {31'd0, walk_rvalid}, 32'd0);
        nxt(); idle_inputs(); rst_n = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rl_post_rvalid", {31'd0, walk_rvalid}, 32'd0);
            nxt();
        end
        fetch_req = 1; fetch_addr = 32'h400;
        @(negedge clk);
        chk("rl_idle_fgnt", {31'd0, fetch_gnt}, 32'd1);
        nxt(); idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
